// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Two-stage valid/ready issue/result pipeline around a combinational
//            ALU, with operand forwarding from the previous op's result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_WIDTH = 3,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ALUControl_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0]       in_a,
  input  logic [DATA_WIDTH-1:0]       in_b,
  input  logic                        in_fwd_a,
  input  logic                        in_fwd_b,
  output logic [ALUControl_WIDTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0]       SrcA,
  output logic [DATA_WIDTH-1:0]       SrcB,
  input  logic [DATA_WIDTH-1:0]       ALUResult,
  input  logic                        zero,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_result,
  output logic                        out_zero,
  output logic [ALUControl_WIDTH-1:0] out_ctrl,
  output logic [CNT_WIDTH-1:0]        op_count
);

  logic                        s1_valid;
  logic [ALUControl_WIDTH-1:0] s1_ctrl;
  logic [DATA_WIDTH-1:0]       s1_a;
  logic [DATA_WIDTH-1:0]       s1_b;

  logic                        s2_valid;
  logic [DATA_WIDTH-1:0]       s2_result;
  logic                        s2_zero;
  logic [ALUControl_WIDTH-1:0] s2_ctrl;

  logic [DATA_WIDTH-1:0]       last_result;
  logic [CNT_WIDTH-1:0]        count;

  logic                        s2_adv;
  logic                        s1_load;
  logic                        handoff;
  logic [DATA_WIDTH-1:0]       fwd_src;
  logic [DATA_WIDTH-1:0]       op_a;
  logic [DATA_WIDTH-1:0]       op_b;

  assign s2_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign s1_load  = in_valid && in_ready;
  assign handoff  = s2_valid && out_ready;

  // An op still in stage 1 has not reached last_result yet, so its live ALU
  // output is the newest value to forward.
  assign fwd_src = s1_valid ? ALUResult : last_result;
  assign op_a    = in_fwd_a ? fwd_src : in_a;
  assign op_b    = in_fwd_b ? fwd_src : in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_ctrl  <= in_ctrl;
      s1_a     <= op_a;
      s1_b     <= op_b;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_zero     <= 1'b0;
      s2_ctrl     <= '0;
      last_result <= '0;
    end else if (s2_adv) begin
      s2_valid    <= 1'b1;
      s2_result   <= ALUResult;
      s2_zero     <= zero;
      s2_ctrl     <= s1_ctrl;
      last_result <= ALUResult;
    end else if (handoff) begin
      s2_valid    <= 1'b0;
    end
  end

  // Saturating completed-op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (handoff && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign ALUControl = s1_ctrl;
  assign SrcA       = s1_a;
  assign SrcB       = s1_b;
  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_ctrl   = s2_ctrl;
  assign op_count   = count;

endmodule
`default_nettype wire
